// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and default sizes for the shared comparator arbiter.
package cmp_pkg;

   localparam int CMP_WIDTH_DEF = 32;
   localparam int CMP_NREQ_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_HOLD = 2'd2
   } cmp_state_e;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_res_t;

endpackage : cmp_pkg

// File: rtl/mag_cmp.sv
// mag_cmp: purely combinational magnitude comparator producing one-hot gt/eq/lt.
// Optional macro CMP_SIGNED_EN: when defined, operands are two's-complement signed.
module mag_cmp
   import cmp_pkg::*;
#(
   parameter int WIDTH = CMP_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output cmp_res_t         res
);

   // One-hot compare result; equality is sign-agnostic so it is shared by both builds.
   always_comb begin
      res = '0;
`ifdef CMP_SIGNED_EN
      if ($signed(a) > $signed(b)) begin
         res.gt = 1'b1;
      end else if (a == b) begin
         res.eq = 1'b1;
      end else begin
         res.lt = 1'b1;
      end
`else
      if (a > b) begin
         res.gt = 1'b1;
      end else if (a == b) begin
         res.eq = 1'b1;
      end else begin
         res.lt = 1'b1;
      end
`endif
   end

endmodule : mag_cmp

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin time-sharing of one comparator among NREQ
// requesters. Accept -> CMP -> HOLD (until rsp_ready) -> IDLE.
// Optional macro CMP_SIGNED_EN selects signed comparison inside mag_cmp only.
module cmp_share_arbiter
   import cmp_pkg::*;
#(
   parameter  int WIDTH = CMP_WIDTH_DEF,
   parameter  int NREQ  = CMP_NREQ_DEF,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic                  rsp_gt,
   output logic                  rsp_eq,
   output logic                  rsp_lt,
   output logic                  busy
);

   // First valid requester at or above ptr, wrapping; result is one-hot or zero.
   function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] valid,
                                                input logic [IDW-1:0]  ptr);
      logic [NREQ-1:0] g;
      logic            found;
      int              idx;
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && valid[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end else begin
            found = found;
         end
      end
      return g;
   endfunction

   cmp_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic             rsp_valid_q, rsp_valid_d;
   cmp_res_t         rsp_res_q, rsp_res_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;

   logic [NREQ-1:0]  grant_s;
   logic [IDW-1:0]   grant_id_s;
   logic [WIDTH-1:0] sel_a_s;
   logic [WIDTH-1:0] sel_b_s;
   logic [IDW-1:0]   ptr_next_s;
   cmp_res_t         cmp_res_s;
   logic [NREQ-1:0]  req_ready_s;
   logic             busy_s;

   // Comparator only ever sees registered operands.
   mag_cmp #(.WIDTH(WIDTH)) u_mag_cmp (
      .a   (a_q),
      .b   (b_q),
      .res (cmp_res_s)
   );

   // Arbitration: one-hot grant, its index and the granted operand pair.
   always_comb begin
      grant_s    = rr_grant(req_valid, ptr_q);
      grant_id_s = '0;
      sel_a_s    = '0;
      sel_b_s    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_s[i]) begin
            grant_id_s = IDW'(i);
         end else begin
            grant_id_s = grant_id_s;
         end
         sel_a_s = sel_a_s | ({WIDTH{grant_s[i]}} & req_a[i*WIDTH +: WIDTH]);
         sel_b_s = sel_b_s | ({WIDTH{grant_s[i]}} & req_b[i*WIDTH +: WIDTH]);
      end
   end

   // Pointer advance after a served request, wrapping at the last index.
   always_comb begin
      if (id_q == IDW'(NREQ - 1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = id_q + IDW'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (|grant_s) begin
               state_d = ST_CMP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMP: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: accept strobe only while idle, busy otherwise.
   always_comb begin
      if (state_q == ST_IDLE) begin
         req_ready_s = grant_s;
         busy_s      = 1'b0;
      end else begin
         req_ready_s = '0;
         busy_s      = 1'b1;
      end
   end

   // Datapath next values: operand capture, result registration, pointer update.
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      ptr_d       = ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_res_d   = rsp_res_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         ST_IDLE: begin
            if (|grant_s) begin
               a_d  = sel_a_s;
               b_d  = sel_b_s;
               id_d = grant_id_s;
            end else begin
               id_d = id_q;
            end
         end
         ST_CMP: begin
            rsp_valid_d = 1'b1;
            rsp_res_d   = cmp_res_s;
            rsp_id_d    = id_q;
         end
         ST_HOLD: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_res_d   = '0;
               ptr_d       = ptr_next_s;
            end else begin
               rsp_valid_d = rsp_valid_q;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            rsp_res_d   = '0;
         end
      endcase
   end

   // Datapath registers; reset drops any in-flight transaction silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_res_q   <= '0;
         rsp_id_q    <= '0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_res_q   <= rsp_res_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign req_ready = req_ready_s;
   assign busy      = busy_s;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_gt    = rsp_res_q.gt;
   assign rsp_eq    = rsp_res_q.eq;
   assign rsp_lt    = rsp_res_q.lt;

endmodule : cmp_share_arbiter

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level reference model of the arbiter.
module tb_cmp_share_arbiter;

   localparam int W   = 32;
   localparam int N   = 4;
   localparam int IDW = 2;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [IDW-1:0]   rsp_id;
   logic             rsp_gt;
   logic             rsp_eq;
   logic             rsp_lt;
   logic             busy;

   cmp_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_gt    (rsp_gt),
      .rsp_eq    (rsp_eq),
      .rsp_lt    (rsp_lt),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests;
   int n_fail;

   // model: 0 = waiting for a request, 1 = comparing, 2 = result offered
   int           m_phase;
   int           m_ptr;
   int           m_id;
   logic [W-1:0] m_a;
   logic [W-1:0] m_b;
   int           grant_log[$];
   int           hs_cnt;
   bit           auto_clear;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // 0 = A>B, 1 = A==B, 2 = A<B, using plain integer arithmetic
   function automatic int ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa;
      longint sb;
`ifdef CMP_SIGNED_EN
      int ia;
      int ib;
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
`else
      sa = {32'd0, a};
      sb = {32'd0, b};
`endif
      if (sa > sb) return 0;
      if (sa == sb) return 1;
      return 2;
   endfunction

   function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   // One clock cycle: entered at a negedge with inputs already driven.
   task automatic cycle();
      int           g;
      int           r;
      logic [N-1:0] er;
      #1;
      g  = (m_phase == 0) ? ref_pick(req_valid, m_ptr) : -1;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check_val("req_ready", req_ready, er);
      check_val("busy", busy, m_phase != 0);
      check_val("rsp_valid", rsp_valid, m_phase == 2);
      if (m_phase == 2) begin
         r = ref_cmp(m_a, m_b);
         check_val("flags", {rsp_gt, rsp_eq, rsp_lt}, {r == 0, r == 1, r == 2});
         check_val("rsp_id", rsp_id, m_id);
      end else begin
         check_val("flags_off", {rsp_gt, rsp_eq, rsp_lt}, 3'b000);
      end
      @(posedge clk);
      case (m_phase)
         0: if (g >= 0) begin
               m_a = req_a[g*W +: W];
               m_b = req_b[g*W +: W];
               m_id = g;
               m_phase = 1;
               grant_log.push_back(g);
            end
         1: m_phase = 2;
         2: if (rsp_ready) begin
               m_phase = 0;
               m_ptr = (m_id + 1) % N;
               hs_cnt++;
            end
         default: m_phase = 0;
      endcase
      @(negedge clk);
      if (g >= 0 && auto_clear) req_valid[g] = 1'b0;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   logic [W-1:0] edge_v[4];
   int           hs_before;
   int           mode;

   initial begin
      n_tests = 0; n_fail = 0;
      m_phase = 0; m_ptr = 0; m_id = 0; m_a = '0; m_b = '0; hs_cnt = 0;
      auto_clear = 1'b1;
      edge_v[0] = 32'h0000_0000; edge_v[1] = 32'hFFFF_FFFF;
      edge_v[2] = 32'h8000_0000; edge_v[3] = 32'h7FFF_FFFF;
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_val("rst_rsp_valid", rsp_valid, 1'b0);
      check_val("rst_flags", {rsp_gt, rsp_eq, rsp_lt}, 3'b000);
      check_val("rst_id", rsp_id, 2'd0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_ready", req_ready, 4'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // all four valid from reset, held valid: order 0,1,2,3,0
      auto_clear = 1'b0;
      rsp_ready = 1'b1;
      set_op(0, 32'd5, 32'd9); set_op(1, 32'd70, 32'd7);
      set_op(2, 32'd33, 32'd33); set_op(3, 32'd1, 32'd2);
      req_valid = 4'b1111;
      for (int k = 0; k < 40 && grant_log.size() < 5; k++) cycle();
      check_val("rr_count", grant_log.size(), 5);
      for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
         check_val("rr_order", grant_log[k], k % N);
      end
      req_valid = '0;
      auto_clear = 1'b1;
      run(4);

      // single equal compare on requester 0
      set_op(0, 32'd10, 32'd10);
      req_valid = 4'b0001;
      cycle();
      check_val("t1_accept", grant_log[$], 0);
      cycle();
      #1;
      check_val("t1_valid", rsp_valid, 1'b1);
      check_val("t1_eq", rsp_eq, 1'b1);
      check_val("t1_id", rsp_id, 2'd0);
      run(2);

      // requester 1: less-than then greater-than
      set_op(1, 32'd100, 32'd120);
      req_valid = 4'b0010;
      run(4);
      set_op(1, 32'd120, 32'd50);
      req_valid = 4'b0010;
      run(4);

      // back-pressure: result held, no accepts while stalled
      rsp_ready = 1'b0;
      set_op(3, 32'd556, 32'd9807);
      req_valid = 4'b1000;
      cycle();
      set_op(1, 32'd3, 32'd4);
      req_valid[1] = 1'b1;
      run(6);
      check_val("bp_lt", rsp_lt, 1'b1);
      hs_before = hs_cnt;
      rsp_ready = 1'b1;
      cycle();
      check_val("bp_one_hs", hs_cnt - hs_before, 1);
      run(5);

      // serve requester 2 so ptr moves to 3, then reset during CMP
      set_op(2, 32'd8, 32'd1);
      req_valid = 4'b0100;
      run(4);
      req_valid = 4'b0100;
      cycle();
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      check_val("arst_valid", rsp_valid, 1'b0);
      check_val("arst_busy", busy, 1'b0);
      check_val("arst_flags", {rsp_gt, rsp_eq, rsp_lt}, 3'b000);
      check_val("arst_id", rsp_id, 2'd0);
      check_val("arst_ready", req_ready, 4'd0);
      m_phase = 0; m_ptr = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      set_op(1, 32'd2, 32'd2); set_op(3, 32'd9, 32'd2);
      req_valid = 4'b1010;
      cycle();
      check_val("arst_lowest", grant_log[$], 1);
      req_valid = '0;
      run(4);

      // all-ones against one
      set_op(2, 32'hFFFF_FFFF, 32'd1);
      req_valid = 4'b0100;
      run(2);
      #1;
`ifdef CMP_SIGNED_EN
      check_val("ones_vs_one", {rsp_gt, rsp_lt}, 2'b01);
`else
      check_val("ones_vs_one", {rsp_gt, rsp_lt}, 2'b10);
`endif
      run(2);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req_valid[i] = 1'b1;
                  mode = $urandom_range(0, 3);
                  case (mode)
                     0: set_op(i, $urandom, $urandom);
                     1: begin
                           req_a[i*W +: W] = $urandom;
                           req_b[i*W +: W] = req_a[i*W +: W];
                        end
                     2: set_op(i, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
                     default: set_op(i, edge_v[$urandom_range(0, 3)], edge_v[$urandom_range(0, 3)]);
                  endcase
               end
            end else if ($urandom_range(0, 39) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         cycle();
      end
      check_val("rand_progress", hs_cnt > 100, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_cmp_share_arbiter
